// File: rtl/alu1_issue_ctrl_if.sv
// Command, ALU operand/opcode and response bundle for alu1_issue_ctrl.
// master: the issue controller (drives the ALU bus and the handshake replies).
// slave : the environment (command source, external ALU, response consumer).
interface alu1_issue_ctrl_if #(
  parameter int WIDTH = 6
);
  // Command channel
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic             cmd_use_acc;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  // ALU operand/opcode bus
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [1:0]       alu_c;
  logic [WIDTH-1:0] alu_f;
  // Response channel
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic [1:0]       rsp_op;

  modport master (
    input  cmd_valid, cmd_op, cmd_use_acc, cmd_a, cmd_b, alu_f, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_c, rsp_valid, rsp_data, rsp_op
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_use_acc, cmd_a, cmd_b, alu_f, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_c, rsp_valid, rsp_data, rsp_op
  );
endinterface

// File: rtl/alu1_issue_ctrl.sv
// alu1_issue_ctrl: initiator for the alu1 operand/opcode bus.
// Accepts one command, presents registered operands/opcode to the external
// ALU for 1+LAT cycles, captures alu_f into the accumulator and returns it on
// the response channel. One operation in flight at a time.
// Optional macro ALU_CHECK_EN: adds a golden model of the ALU and a sticky
// err flag raised when alu_f disagrees with it at the sample edge.
module alu1_issue_ctrl #(
  parameter int WIDTH = 6,
  parameter int LAT   = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  alu1_issue_ctrl_if.master   bus,
  output logic [WIDTH-1:0]    acc,
  output logic [7:0]          op_count,
  output logic                err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0] state;
  logic [2:0] wait_cnt;
  logic       sample_now;

  // The ALU result is taken on the last EXEC cycle.
  assign sample_now = (state == S_EXEC) && (wait_cnt == 3'd0);

  // Handshake outputs decode straight from the registered state, so they are
  // glitch-free and take their reset values together with the state.
  assign bus.cmd_ready = (state == S_IDLE);
  assign bus.rsp_valid = (state == S_RESP);

  // Main controller: command capture, latency count, result capture, response.
  // NOTE: sequential state uses non-blocking assignments only, so every branch
  // reads the pre-edge values (e.g. acc for cmd_use_acc is the previous result).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      wait_cnt     <= 3'd0;
      bus.alu_a    <= '0;
      bus.alu_b    <= '0;
      bus.alu_c    <= 2'b00;
      bus.rsp_data <= '0;
      bus.rsp_op   <= 2'b00;
      acc          <= '0;
      op_count     <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            bus.alu_a <= bus.cmd_use_acc ? acc : bus.cmd_a;
            bus.alu_b <= bus.cmd_b;
            bus.alu_c <= bus.cmd_op;
            wait_cnt  <= 3'(LAT);
            state     <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (wait_cnt != 3'd0) begin
            wait_cnt <= wait_cnt - 3'd1;
          end else begin
            bus.rsp_data <= bus.alu_f;
            bus.rsp_op   <= bus.alu_c;
            acc          <= bus.alu_f;
            state        <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            op_count <= op_count + 8'd1;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ALU_CHECK_EN
  logic [WIDTH-1:0] golden_f;

  // Golden ALU: 00 A+B+1, 01 A, 10 A&B, 11 A-B, all wrap-around.
  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    golden_f = '0;
    case (bus.alu_c)
      2'b00:   golden_f = bus.alu_a + bus.alu_b + WIDTH'(1);
      2'b01:   golden_f = bus.alu_a;
      2'b10:   golden_f = bus.alu_a & bus.alu_b;
      default: golden_f = bus.alu_a - bus.alu_b;
    endcase
  end

  // Sticky mismatch flag, set only at the sample edge, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (sample_now && (bus.alu_f != golden_f)) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
